ec_pt_mul_seq: RTL and testbench
================================

EC_PT_MUL_SEQ -- requirements
Module: ec_pt_mul_seq

Interface
REQ-001 Parameter SCL_BITS, default 256: scalar width in bits.
REQ-002 i_clk  input  1  sole clock; all logic rising-edge.
REQ-003 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 i_k  input  SCL_BITS  scalar k.
REQ-005 i_p  input  jb_point_t  base point P (Jacobian, z==0 means infinity).
REQ-006 i_val / o_rdy  input/output  1/1  job handshake; transfer when both high.
REQ-007 o_pt_op  output  pt_op_t  DBL or ADD request to shared point unit.
REQ-008 o_pt_a, o_pt_b  output  jb_point_t  operands (ADD: acc, P; DBL: acc in a, b don't-care).
REQ-009 o_pt_val / i_pt_rdy  output/input  1/1  request handshake.
REQ-010 i_pt_res, i_pt_res_val  input  jb_point_t/1  point-unit result, one-cycle pulse.
REQ-011 o_res, o_res_val / i_res_rdy  output/input  jb_point_t, 1/1  result handshake.

Function
REQ-012 The block SHALL compute k*P by MSB-first double-and-add using the shared point unit; it SHALL perform no field arithmetic itself.
REQ-013 States SHALL be: IDLE, SCAN, DBL_REQ, DBL_WAIT, ADD_REQ, ADD_WAIT, DONE.
REQ-014 IDLE: o_rdy=1; on transfer, latch k and P, clear acc to infinity (all zero), set bit index to SCL_BITS-1, go SCAN.
REQ-015 SCAN: locate the first set bit (see REQ-026/027); on finding bit i, set acc=P with no op issued, index=i-1, go DBL_REQ if i>0 else DONE; if k==0, go DONE with acc=infinity.
REQ-016 DBL_REQ: o_pt_val=1, op=DBL, a=acc; hold o_pt_val and operands stable until i_pt_rdy; then DBL_WAIT.
REQ-017 DBL_WAIT: on i_pt_res_val, acc=i_pt_res; go ADD_REQ if k[index]=1, else decrement index (or DONE if index==0).
REQ-018 ADD_REQ/ADD_WAIT: same handshake with op=ADD, a=acc, b=P; after result, decrement index or go DONE if index==0.
REQ-019 i_pt_res_val outside DBL_WAIT/ADD_WAIT SHALL be ignored.
REQ-020 At most one point-unit request SHALL be outstanding.
REQ-021 DONE: o_res_val=1, o_res=acc, held stable until i_res_rdy; then IDLE. o_rdy SHALL be 0 in all states except IDLE.
REQ-022 Op count for k with MSB at position m SHALL be exactly m DBL plus (popcount(k)-1) ADD; k=0 or 1 issues zero ops.
REQ-023 P with z==0 SHALL still be sequenced normally (point unit returns infinity).

Reset
REQ-024 Async assertion of i_rst_n low SHALL force IDLE immediately: o_rdy=0 while in reset, o_pt_val=0, o_res_val=0, acc=0; after deassertion o_rdy=1 on next cycle.
REQ-025 Reset mid-job SHALL abandon the job; a point-unit result arriving after reset SHALL be ignored.

Configuration
REQ-026 With EC_PT_MUL_LZ_SKIP_EN defined, SCAN SHALL find the MSB in one cycle via a leading-one detector.
REQ-027 Without it, SCAN SHALL test one bit per cycle from SCL_BITS-1 downward (k=0 spends SCL_BITS cycles in SCAN); results and op counts SHALL be identical in both builds.

Structure
REQ-028 pt_op_t enum (DBL, ADD) SHALL be added to bn128_pkg; jb_point_t and DAT_BITS SHALL come from bn128_pkg.
REQ-029 One sub-module, lod_msb (parameterised leading-one detector returning index and zero flag), SHALL be instantiated only under EC_PT_MUL_LZ_SKIP_EN.

Verification
REQ-030 k=0, P=G1_JB, LZ_SKIP on -> o_res_val 2 cycles after accept, o_res.z=0, zero o_pt_val pulses.
REQ-031 k=1, P=G1_JB -> o_res == G1_JB exactly (x=1,y=2,z=1), zero ops.
REQ-032 k=2 then k=3, P=G1_JB, model point unit latency 5 -> ops {DBL} and {DBL,ADD}; to_affine(o_res) equals package point_mult result.
REQ-033 k=2^256-1 with i_pt_rdy toggling 50% and i_res_rdy held low 10 cycles -> 255 DBL + 255 ADD, operands stable while stalled, o_res held, result matches point_mult.
REQ-034 Reset asserted during ADD_WAIT, stale i_pt_res_val pulsed after release -> IDLE, o_pt_val=0, no o_res_val; next job k=5 yields correct 5*G1.
REQ-035 Build without EC_PT_MUL_LZ_SKIP_EN, k=0 -> o_res_val after SCL_BITS+1 cycles, results of REQ-031..033 unchanged.

Source files
------------

// File: rtl/bn128_pkg.sv
// BN128 shared types for the point-arithmetic datapath.
//   DAT_BITS   : field element width
//   jb_point_t : Jacobian point {x, y, z}; z == 0 encodes the point at infinity
//   pt_op_t    : request type for the shared point unit (DBL / ADD)
package bn128_pkg;

  localparam int unsigned DAT_BITS = 256;

  typedef struct packed {
    logic [DAT_BITS-1:0] x;
    logic [DAT_BITS-1:0] y;
    logic [DAT_BITS-1:0] z;
  } jb_point_t;

  typedef enum logic {
    DBL = 1'b0,
    ADD = 1'b1
  } pt_op_t;

  localparam jb_point_t JB_INF = '0;
  localparam jb_point_t G1_JB  = '{x: DAT_BITS'(1), y: DAT_BITS'(2), z: DAT_BITS'(1)};

endpackage

// File: rtl/ec_pt_mul_seq_lod_msb.sv
// Leading-one detector: index of the most significant set bit of vec.
//   vec  : input vector (W bits)
//   idx  : position of the highest set bit (0 when vec is all zero)
//   zero : high when vec has no set bit
module lod_msb #(
  parameter int unsigned W  = 256,
  parameter int unsigned IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          zero
);

  // Ascending scan: the last set bit seen is the MSB.
  always_comb begin
    idx  = '0;
    zero = 1'b1;
    for (int unsigned i = 0; i < W; i++) begin
      if (vec[i]) begin
        idx  = IW'(i);
        zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ec_pt_mul_seq.sv
// Sequencer for k*P by MSB-first double-and-add over a shared point unit.
// No field arithmetic here: every DBL/ADD is requested from the point unit.
// Build option: EC_PT_MUL_LZ_SKIP_EN -- find the scalar MSB in one cycle with a
// leading-one detector instead of scanning one bit per cycle.
// Ports:
//   i_clk, i_rst_n        : clock, async active-low reset
//   i_k, i_p              : scalar and base point of a job
//   i_val / o_rdy         : job handshake
//   o_pt_op, o_pt_a/b     : point-unit request (ADD: acc+P, DBL: 2*acc)
//   o_pt_val / i_pt_rdy   : point-unit request handshake
//   i_pt_res/_val         : point-unit result, single-cycle pulse
//   o_res, o_res_val / i_res_rdy : result handshake
module ec_pt_mul_seq
  import bn128_pkg::*;
#(
  parameter int unsigned SCL_BITS = 256
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [SCL_BITS-1:0] i_k,
  input  jb_point_t           i_p,
  input  logic                i_val,
  output logic                o_rdy,
  output pt_op_t              o_pt_op,
  output jb_point_t           o_pt_a,
  output jb_point_t           o_pt_b,
  output logic                o_pt_val,
  input  logic                i_pt_rdy,
  input  jb_point_t           i_pt_res,
  input  logic                i_pt_res_val,
  output jb_point_t           o_res,
  output logic                o_res_val,
  input  logic                i_res_rdy
);

  localparam int unsigned IDX_BITS = (SCL_BITS > 1) ? $clog2(SCL_BITS) : 1;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SCAN     = 3'd1;
  localparam logic [2:0] ST_DBL_REQ  = 3'd2;
  localparam logic [2:0] ST_DBL_WAIT = 3'd3;
  localparam logic [2:0] ST_ADD_REQ  = 3'd4;
  localparam logic [2:0] ST_ADD_WAIT = 3'd5;
  localparam logic [2:0] ST_DONE     = 3'd6;

  logic [2:0]          state_q, state_d;
  logic [SCL_BITS-1:0] k_q, k_d;
  jb_point_t           p_q, p_d;
  jb_point_t           acc_q, acc_d;
  logic [IDX_BITS-1:0] idx_q, idx_d;

`ifdef EC_PT_MUL_LZ_SKIP_EN
  logic [IDX_BITS-1:0] lod_idx;
  logic                lod_zero;

  lod_msb #(
    .W  (SCL_BITS),
    .IW (IDX_BITS)
  ) u_lod (
    .vec  (k_q),
    .idx  (lod_idx),
    .zero (lod_zero)
  );
`endif

  // State and job registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      p_q     <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      p_q     <= p_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic; handshakes qualify on the registered valid/ready outputs.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    p_d     = p_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (i_val && o_rdy) begin
          k_d     = i_k;
          p_d     = i_p;
          acc_d   = JB_INF;
          idx_d   = IDX_BITS'(SCL_BITS - 1);
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
`ifdef EC_PT_MUL_LZ_SKIP_EN
        if (lod_zero) begin
          state_d = ST_DONE;
        end else begin
          // Top set bit folds into acc = P without a point-unit op.
          acc_d = p_q;
          if (lod_idx != '0) begin
            idx_d   = IDX_BITS'(lod_idx - 1'b1);
            state_d = ST_DBL_REQ;
          end else begin
            state_d = ST_DONE;
          end
        end
`else
        if (k_q[idx_q]) begin
          acc_d = p_q;
          if (idx_q != '0) begin
            idx_d   = IDX_BITS'(idx_q - 1'b1);
            state_d = ST_DBL_REQ;
          end else begin
            state_d = ST_DONE;
          end
        end else if (idx_q == '0) begin
          state_d = ST_DONE;
        end else begin
          idx_d = IDX_BITS'(idx_q - 1'b1);
        end
`endif
      end
      ST_DBL_REQ: begin
        if (o_pt_val && i_pt_rdy) state_d = ST_DBL_WAIT;
      end
      ST_DBL_WAIT: begin
        if (i_pt_res_val) begin
          acc_d = i_pt_res;
          if (k_q[idx_q]) begin
            state_d = ST_ADD_REQ;
          end else if (idx_q == '0) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = IDX_BITS'(idx_q - 1'b1);
            state_d = ST_DBL_REQ;
          end
        end
      end
      ST_ADD_REQ: begin
        if (o_pt_val && i_pt_rdy) state_d = ST_ADD_WAIT;
      end
      ST_ADD_WAIT: begin
        if (i_pt_res_val) begin
          acc_d = i_pt_res;
          if (idx_q == '0) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = IDX_BITS'(idx_q - 1'b1);
            state_d = ST_DBL_REQ;
          end
        end
      end
      ST_DONE: begin
        if (o_res_val && i_res_rdy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs decoded from next state; acc/P are frozen while a
  // request or result is pending, so operands stay stable under stall.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rdy     <= 1'b0;
      o_pt_val  <= 1'b0;
      o_pt_op   <= DBL;
      o_pt_a    <= '0;
      o_pt_b    <= '0;
      o_res_val <= 1'b0;
      o_res     <= '0;
    end else begin
      o_rdy     <= (state_d == ST_IDLE);
      o_pt_val  <= (state_d == ST_DBL_REQ) || (state_d == ST_ADD_REQ);
      o_pt_op   <= (state_d == ST_ADD_REQ) ? ADD : DBL;
      o_pt_a    <= acc_d;
      o_pt_b    <= p_d;
      o_res_val <= (state_d == ST_DONE);
      o_res     <= acc_d;
    end
  end

endmodule

// File: tb/tb_ec_pt_mul_seq.sv
// Bench for ec_pt_mul_seq. The point unit is a stand-in additive group in which
// a point (x, y, z) behaves like the multiple x of G1 = (1, 2, 1):
// DBL -> (2x, 2y, z), ADD -> (x1+x2, y1+y2, z1|z2), so k*G1 = (k, 2k, k!=0).
`timescale 1ns/1ps
module tb_ec_pt_mul_seq;
  import bn128_pkg::*;

  localparam int unsigned SCL_BITS = 256;
  localparam int PU_LAT  = 5;
  localparam int MAX_CYC = 20000;
`ifdef EC_PT_MUL_LZ_SKIP_EN
  localparam int K0_CYC = 2;
`else
  localparam int K0_CYC = SCL_BITS + 1;
`endif

  typedef pt_op_t op_q_t[$];

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [SCL_BITS-1:0] i_k = '0;
  jb_point_t           i_p = '0;
  logic                i_val = 1'b0;
  logic                o_rdy;
  pt_op_t              o_pt_op;
  jb_point_t           o_pt_a, o_pt_b;
  logic                o_pt_val;
  logic                i_pt_rdy = 1'b0;
  jb_point_t           i_pt_res = '0;
  logic                i_pt_res_val = 1'b0;
  jb_point_t           o_res;
  logic                o_res_val;
  logic                i_res_rdy = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  op_q_t     got_ops;
  jb_point_t job_res;
  int        job_cyc;
  int        stab_err;
  int        olap_err;
  bit        job_to;

  always #5 clk = ~clk;

  ec_pt_mul_seq #(.SCL_BITS(SCL_BITS)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_k          (i_k),
    .i_p          (i_p),
    .i_val        (i_val),
    .o_rdy        (o_rdy),
    .o_pt_op      (o_pt_op),
    .o_pt_a       (o_pt_a),
    .o_pt_b       (o_pt_b),
    .o_pt_val     (o_pt_val),
    .i_pt_rdy     (i_pt_rdy),
    .i_pt_res     (i_pt_res),
    .i_pt_res_val (i_pt_res_val),
    .o_res        (o_res),
    .o_res_val    (o_res_val),
    .i_res_rdy    (i_res_rdy)
  );

  function automatic jb_point_t exp_mul(input logic [SCL_BITS-1:0] k);
    jb_point_t r;
    r.x = DAT_BITS'(k);
    r.y = DAT_BITS'(k << 1);
    r.z = (k != '0) ? DAT_BITS'(1) : DAT_BITS'(0);
    return r;
  endfunction

  function automatic op_q_t exp_ops(input logic [SCL_BITS-1:0] k);
    op_q_t q;
    int msb = -1;
    for (int i = 0; i < int'(SCL_BITS); i++) if (k[i]) msb = i;
    for (int i = msb - 1; i >= 0; i--) begin
      q.push_back(DBL);
      if (k[i]) q.push_back(ADD);
    end
    return q;
  endfunction

  function automatic bit ops_match(input op_q_t e);
    if (e.size() != got_ops.size()) return 1'b0;
    foreach (e[i]) if (e[i] != got_ops[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int count_op(input pt_op_t op);
    int n = 0;
    foreach (got_ops[i]) if (got_ops[i] == op) n++;
    return n;
  endfunction

  // Drives one job and plays the point unit and result sink; all at negedge.
  task automatic run_job(input logic [SCL_BITS-1:0] k, input jb_point_t p,
                         input bit toggle, input int res_stall, input bit abort_on_add);
    int cyc, cnt, stall;
    bit busy, held, seen;
    jb_point_t pend, s_a, s_b, s_res;
    pt_op_t s_op;
    got_ops.delete();
    stab_err = 0; olap_err = 0; job_to = 1'b0; job_cyc = -1; job_res = '0;
    cnt = 0; stall = 0; busy = 1'b0; held = 1'b0; seen = 1'b0;
    s_op = DBL; s_a = '0; s_b = '0; s_res = '0; pend = '0;
    i_pt_rdy = 1'b0; i_pt_res_val = 1'b0; i_res_rdy = 1'b0;
    cyc = 0;
    while (!o_rdy && cyc < 100) begin @(negedge clk); cyc++; end
    if (!o_rdy) begin job_to = 1'b1; return; end
    i_k = k; i_p = p; i_val = 1'b1;
    @(negedge clk);
    i_val = 1'b0;
    cyc = 1;
    while (cyc < MAX_CYC) begin
      i_pt_res_val = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin i_pt_res = pend; i_pt_res_val = 1'b1; busy = 1'b0; end
      end
      i_pt_rdy = toggle ? ~i_pt_rdy : 1'b1;
      if (o_pt_val) begin
        if (held && (o_pt_op !== s_op || o_pt_a !== s_a || (o_pt_op == ADD && o_pt_b !== s_b)))
          stab_err++;
        s_op = o_pt_op; s_a = o_pt_a; s_b = o_pt_b;
        if (i_pt_rdy) begin
          if (busy) olap_err++;
          got_ops.push_back(o_pt_op);
          if (o_pt_op == ADD)
            pend = '{x: o_pt_a.x + o_pt_b.x, y: o_pt_a.y + o_pt_b.y, z: o_pt_a.z | o_pt_b.z};
          else
            pend = '{x: o_pt_a.x + o_pt_a.x, y: o_pt_a.y + o_pt_a.y, z: o_pt_a.z};
          busy = 1'b1; cnt = PU_LAT; held = 1'b0;
          if (abort_on_add && o_pt_op == ADD) begin
            @(negedge clk);
            @(negedge clk);
            return;
          end
        end else begin
          held = 1'b1;
        end
      end else begin
        held = 1'b0;
      end
      if (o_res_val) begin
        if (!seen) begin seen = 1'b1; job_cyc = cyc; s_res = o_res; end
        else if (o_res !== s_res) stab_err++;
        if (stall >= res_stall) begin
          i_res_rdy = 1'b1; job_res = o_res;
          @(negedge clk);
          i_res_rdy = 1'b0; i_pt_rdy = 1'b0; i_pt_res_val = 1'b0;
          return;
        end
        stall++;
      end
      @(negedge clk);
      cyc++;
    end
    job_to = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (o_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: got %0b want 0", o_rdy); end
    n_checks++; if (o_pt_val !== 1'b0) begin n_fail++; $display("FAIL reset_pt_val: got %0b want 0", o_pt_val); end
    n_checks++; if (o_res_val !== 1'b0) begin n_fail++; $display("FAIL reset_res_val: got %0b want 0", o_res_val); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (o_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_release_rdy: got %0b want 1", o_rdy); end
  endtask

  task automatic test_k_zero();
    run_job('0, G1_JB, 1'b0, 0, 1'b0);
    n_checks++; if (job_to !== 1'b0) begin n_fail++; $display("FAIL k0_timeout: got %0b want 0", job_to); end
    n_checks++; if (job_cyc != K0_CYC) begin n_fail++; $display("FAIL k0_latency: got %0d want %0d", job_cyc, K0_CYC); end
    n_checks++; if (job_res.z !== '0) begin n_fail++; $display("FAIL k0_res_z: got %0h want 0", job_res.z); end
    n_checks++; if (got_ops.size() != 0) begin n_fail++; $display("FAIL k0_ops: got %0d want 0", got_ops.size()); end
  endtask

  task automatic test_k_one();
    run_job(SCL_BITS'(1), G1_JB, 1'b0, 0, 1'b0);
    n_checks++; if (job_res !== G1_JB) begin n_fail++; $display("FAIL k1_res: got %0h want %0h", job_res, G1_JB); end
    n_checks++; if (got_ops.size() != 0 || job_to) begin n_fail++; $display("FAIL k1_ops: got %0d want 0", got_ops.size()); end
  endtask

  task automatic test_k_small();
    logic [SCL_BITS-1:0] k;
    for (int v = 2; v <= 3; v++) begin
      k = SCL_BITS'(v);
      run_job(k, G1_JB, 1'b0, 0, 1'b0);
      n_checks++; if (!ops_match(exp_ops(k)) || job_to) begin n_fail++; $display("FAIL k%0d_ops: got %0d ops want %0d", v, got_ops.size(), v - 1); end
      n_checks++; if (job_res !== exp_mul(k)) begin n_fail++; $display("FAIL k%0d_res: got %0h want %0h", v, job_res, exp_mul(k)); end
    end
  endtask

  task automatic test_inf_point();
    run_job(SCL_BITS'(3), JB_INF, 1'b0, 0, 1'b0);
    n_checks++; if (!ops_match(exp_ops(SCL_BITS'(3))) || job_to) begin n_fail++; $display("FAIL inf_ops: got %0d ops want 2", got_ops.size()); end
    n_checks++; if (job_res !== JB_INF) begin n_fail++; $display("FAIL inf_res: got %0h want 0", job_res); end
  endtask

  task automatic test_all_ones_stall();
    logic [SCL_BITS-1:0] k;
    k = '1;
    run_job(k, G1_JB, 1'b1, 10, 1'b0);
    n_checks++; if (job_to !== 1'b0) begin n_fail++; $display("FAIL ones_timeout: got %0b want 0", job_to); end
    n_checks++; if (count_op(DBL) != 255) begin n_fail++; $display("FAIL ones_dbl: got %0d want 255", count_op(DBL)); end
    n_checks++; if (count_op(ADD) != 255) begin n_fail++; $display("FAIL ones_add: got %0d want 255", count_op(ADD)); end
    n_checks++; if (!ops_match(exp_ops(k))) begin n_fail++; $display("FAIL ones_order: got %0d ops want 510", got_ops.size()); end
    n_checks++; if (stab_err != 0) begin n_fail++; $display("FAIL ones_stable: got %0d unstable cycles want 0", stab_err); end
    n_checks++; if (olap_err != 0) begin n_fail++; $display("FAIL ones_outstanding: got %0d overlaps want 0", olap_err); end
    n_checks++; if (job_res !== exp_mul(k)) begin n_fail++; $display("FAIL ones_res: got %0h want %0h", job_res, exp_mul(k)); end
  endtask

  task automatic test_reset_mid_job();
    int bad;
    run_job(SCL_BITS'(11), G1_JB, 1'b0, 0, 1'b1);
    n_checks++; if (got_ops.size() != 3 || got_ops[got_ops.size()-1] != ADD) begin n_fail++; $display("FAIL abort_reach_add: got %0d ops want 3", got_ops.size()); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (o_rdy !== 1'b0 || o_pt_val !== 1'b0 || o_res_val !== 1'b0) begin
      n_fail++; $display("FAIL abort_async: got rdy=%0b pt_val=%0b res_val=%0b want 0 0 0", o_rdy, o_pt_val, o_res_val); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    i_pt_rdy = 1'b1;
    i_pt_res = '{x: DAT_BITS'(77), y: DAT_BITS'(88), z: DAT_BITS'(1)};
    i_pt_res_val = 1'b1;
    @(negedge clk);
    i_pt_res_val = 1'b0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (o_pt_val !== 1'b0 || o_res_val !== 1'b0 || o_rdy !== 1'b1) bad++;
      @(negedge clk);
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL abort_idle: got %0d bad cycles want 0", bad); end
    run_job(SCL_BITS'(5), G1_JB, 1'b0, 0, 1'b0);
    n_checks++; if (!ops_match(exp_ops(SCL_BITS'(5))) || job_to) begin n_fail++; $display("FAIL abort_k5_ops: got %0d ops want 3", got_ops.size()); end
    n_checks++; if (job_res !== exp_mul(SCL_BITS'(5))) begin n_fail++; $display("FAIL abort_k5_res: got %0h want %0h", job_res, exp_mul(SCL_BITS'(5))); end
  endtask

  initial begin
    test_reset();
    test_k_zero();
    test_k_one();
    test_k_small();
    test_inf_point();
    test_all_ones_stall();
    test_reset_mid_job();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
